// File: rtl/ps2_fifo_sb_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_fifo_sb_ctrl_if
// Purpose  : System-bus and interrupt signals of the PS/2 keyboard FIFO block.
// Revision : 1.0 - initial release
// ============================================================================
interface ps2_fifo_sb_ctrl_if;
    logic [31:0] addr_i;
    logic        req_i;
    logic        write_enable_i;
    logic [31:0] write_data_i;
    logic [31:0] read_data_o;
    logic        interrupt_request_o;
    logic        interrupt_return_i;

    modport master (
        output addr_i, req_i, write_enable_i, write_data_i, interrupt_return_i,
        input  read_data_o, interrupt_request_o
    );

    modport slave (
        input  addr_i, req_i, write_enable_i, write_data_i, interrupt_return_i,
        output read_data_o, interrupt_request_o
    );
endinterface
`default_nettype wire

// File: rtl/ps2_fifo_sb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ps2_fifo_sb_ctrl
// Purpose  : PS/2 frame receiver with scan-code FIFO, status and masked IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_fifo_sb_ctrl #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int SYNC_STAGES    = 2
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    ps2_fifo_sb_ctrl_if.slave  bus,
    input  wire logic          kclk_i,
    input  wire logic          kdata_i
);
    localparam int c_AW    = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_AW + 1;
    localparam int c_TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0]  c_TO_LIMIT = c_TO_W'(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    // ---------------- synchronisers and edge detect ----------------
    logic [SYNC_STAGES-1:0] r_kclk_sync;
    logic [SYNC_STAGES-1:0] r_kdata_sync;
    logic                   r_kclk_last;
    logic                   w_kclk;
    logic                   w_kdata;
    logic                   w_fall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_kclk_sync  <= '1;
            r_kdata_sync <= '1;
            r_kclk_last  <= 1'b1;
        end else begin
            r_kclk_sync  <= {r_kclk_sync[SYNC_STAGES-2:0], kclk_i};
            r_kdata_sync <= {r_kdata_sync[SYNC_STAGES-2:0], kdata_i};
            r_kclk_last  <= w_kclk;
        end
    end

    assign w_kclk  = r_kclk_sync[SYNC_STAGES-1];
    assign w_kdata = r_kdata_sync[SYNC_STAGES-1];
    assign w_fall  = r_kclk_last & ~w_kclk;

    // ---------------- bus decode ----------------
    logic [23:0] w_addr;
    logic        w_rd;
    logic        w_wr;
    logic        w_flush;
    logic        w_unused;

    assign w_addr   = bus.addr_i[23:0];
    assign w_rd     = bus.req_i & ~bus.write_enable_i;
    assign w_wr     = bus.req_i &  bus.write_enable_i;
    assign w_flush  = w_wr && (w_addr == 24'h24) && (bus.write_data_i == 32'd1);
    assign w_unused = &{1'b0, bus.addr_i[31:24]};

    // ---------------- receiver FSM ----------------
    rx_state_t          r_state;
    rx_state_t          w_state_next;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_parity;
    logic [c_TO_W-1:0]  r_to_cnt;
    logic               w_frame_good;
    logic               w_frame_bad;
    logic               w_timeout;

    always_ff @(posedge clk_i) begin
        if (rst_i || w_flush) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_frame_good = 1'b0;
        w_frame_bad  = 1'b0;
        w_timeout    = 1'b0;
        if ((r_state != ST_IDLE) && !w_fall && (r_to_cnt == c_TO_LIMIT)) begin
            w_timeout    = 1'b1;
            w_state_next = ST_IDLE;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE:   if (!w_kdata) w_state_next = ST_DATA;
                ST_DATA:   if (r_bit_idx == 3'd7) w_state_next = ST_PARITY;
                ST_PARITY: w_state_next = ST_STOP;
                ST_STOP: begin
                    w_state_next = ST_IDLE;
                    // odd parity: XOR of data and parity bit must be 1
                    if (w_kdata && (^{r_shift, r_parity})) w_frame_good = 1'b1;
                    else                                   w_frame_bad  = 1'b1;
                end
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || w_flush) begin
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_parity  <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            if ((r_state == ST_IDLE) || w_fall) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != c_TO_LIMIT) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_fall) begin
                case (r_state)
                    ST_IDLE:   r_bit_idx <= 3'd0;
                    ST_DATA: begin
                        r_shift   <= {w_kdata, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end
                    ST_PARITY: r_parity <= w_kdata;
                    default:   ;
                endcase
            end
        end
    end

    // ---------------- scan-code FIFO ----------------
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_next;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_ovf_evt;

    assign w_full    = (r_count == c_DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_push    = w_frame_good & ~w_full;
    assign w_ovf_evt = w_frame_good &  w_full;
    assign w_pop     = w_rd && (w_addr == 24'h00) && !w_empty;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop)      w_count_next = r_count + 1'b1;
        else if (!w_push && w_pop) w_count_next = r_count - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= r_shift;
    end

    // ---------------- status, control, interrupt ----------------
    logic [2:0]  r_status;
    logic [2:0]  w_status_set;
    logic [2:0]  w_status_clr;
    logic        r_irq_en;
    logic        r_pending;
    logic        r_rearm;
    logic [31:0] r_read_data;

    assign w_status_set = {w_timeout, w_frame_bad, w_ovf_evt};
    assign w_status_clr = (w_wr && (w_addr == 24'h0C)) ? bus.write_data_i[2:0] : 3'b000;

    always_ff @(posedge clk_i) begin
        if (rst_i || w_flush) begin
            r_status <= 3'b000;
        end else begin
            r_status <= w_status_set | (r_status & ~w_status_clr);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_irq_en <= 1'b1;
        end else if (w_wr && (w_addr == 24'h10)) begin
            r_irq_en <= bus.write_data_i[0];
        end
    end

    // a return with codes still queued re-raises the request one cycle later
    always_ff @(posedge clk_i) begin
        if (rst_i || w_flush) begin
            r_pending <= 1'b0;
            r_rearm   <= 1'b0;
        end else begin
            r_rearm <= bus.interrupt_return_i && (w_count_next != '0);
            if (bus.interrupt_return_i) r_pending <= 1'b0;
            else                        r_pending <= r_pending | w_push | r_rearm;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_read_data <= 32'd0;
        end else if (w_rd) begin
            case (w_addr)
                24'h00:  r_read_data <= w_empty ? 32'd0 : {24'd0, r_mem[r_rd_ptr]};
                24'h04:  r_read_data <= {31'd0, ~w_empty};
                24'h08:  r_read_data <= {{(32-c_CNT_W){1'b0}}, r_count};
                24'h0C:  r_read_data <= {29'd0, r_status};
                24'h10:  r_read_data <= {31'd0, r_irq_en};
                default: r_read_data <= 32'd0;
            endcase
        end
    end

    assign bus.read_data_o         = r_read_data;
    assign bus.interrupt_request_o = r_pending & r_irq_en;

endmodule
`default_nettype wire
